// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

  // Length field: 16-bit little-endian word count, sent as two bytes
  localparam int LEN_W      = 16;
  // Payload words are 4 little-endian bytes
  localparam int WORD_BYTES = 4;
  // Checksum: XOR of all payload bytes, starting from zero
  localparam int CSUM_W     = 8;
  localparam logic [CSUM_W-1:0] CSUM_INIT = '0;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit words.
// Latency: combinational word/done on the 4th byte; lane state updates on the accepting edge.
// Backpressure: none of its own; it only advances on byte_en, which the owner qualifies with ready.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word_dat,
  output logic        word_done
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [WORD_BYTES-1:0][7:0] lanes;
  logic [WORD_BYTES-1:0][7:0] merged;
  logic [IDX_W-1:0]           byte_idx;

  // Store each accepted byte in its lane and advance the lane index (wraps per word)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (clr) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (byte_en) begin
      lanes[byte_idx] <= byte_dat;
      byte_idx        <= byte_idx + 1'b1;
    end
  end

  // Present the word including the byte arriving this cycle, so the owner can register it directly
  always_comb begin
    merged           = lanes;
    merged[byte_idx] = byte_dat;
  end

  assign word_dat  = merged;
  assign word_done = byte_en && (byte_idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory, then releases the core.
// Latency: one imem write the cycle after each word's 4th byte; RUN/ERROR the cycle after the checksum byte.
// Backpressure: o_byte_ready high only in LEN0/LEN1/DATA/CSUM; bytes move on i_byte_valid && o_byte_ready.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_rst_n,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_WORDS);

  state_t              state;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    word_idx;
  logic [CSUM_W-1:0]   csum_acc;
  logic [LEN_W-1:0]    rx_len;
  logic                xfer;
  logic                restart;
  logic                asm_en;
  logic [31:0]         asm_word;
  logic                asm_done;

  assign xfer    = i_byte_valid && o_byte_ready;
  // Start is honoured only while not loading; mid-load pulses are dropped
  assign restart = i_start && (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
  assign asm_en  = xfer && (state == ST_DATA);
  // Full length as it becomes known on the LEN_HI byte
  assign rx_len  = {i_byte, len[7:0]};

  word_assembler u_asm (
    .clk       (i_clk),
    .rst       (i_rst),
    .clr       (restart),
    .byte_en   (asm_en),
    .byte_dat  (i_byte),
    .word_dat  (asm_word),
    .word_done (asm_done)
  );

  // Loader FSM with length/word counters, checksum accumulator and registered imem write port
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      len          <= '0;
      word_idx     <= '0;
      csum_acc     <= CSUM_INIT;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
    end else begin
      o_imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (i_start) begin
            state    <= ST_LEN0;
            len      <= '0;
            word_idx <= '0;
            csum_acc <= CSUM_INIT;
          end
        end
        ST_LEN0: begin
          if (xfer) begin
            len[7:0] <= i_byte;
            state    <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (xfer) begin
            len[15:8] <= i_byte;
            if ({1'b0, rx_len} > MAX_LEN) state <= ST_ERROR;
            else if (rx_len == '0)        state <= ST_CSUM;
            else                          state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum_acc <= csum_acc ^ i_byte;
            if (asm_done) begin
              o_imem_we    <= 1'b1;
              o_imem_addr  <= BASE_ADDR + {14'b0, word_idx, 2'b00};
              o_imem_wdata <= asm_word;
              word_idx     <= word_idx + 1'b1;
              if (word_idx == len - 1'b1) state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) state <= (i_byte == csum_acc) ? ST_RUN : ST_ERROR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state register
  assign o_byte_ready = (state == ST_LEN0) || (state == ST_LEN1) ||
                        (state == ST_DATA) || (state == ST_CSUM);
  assign o_busy       = o_byte_ready;
  assign o_done       = (state == ST_RUN);
  assign o_core_rst_n = (state == ST_RUN);
  assign o_err        = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances share one byte stream (default params, and BASE 0x100 / MAX_WORDS 4).
// Latency: writes sampled on the falling edge; status checked 1 time unit after the rising edge.
// Backpressure: the byte driver holds valid until the loader shows ready, with random idle gaps between bytes.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_dat;

  logic        rdy0, we0, crn0, busy0, done0, err0;
  logic [31:0] addr0, wdata0;
  logic        rdy1, we1, crn1, busy1, done1, err1;
  logic [31:0] addr1, wdata1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  logic [7:0]  stim[$];
  int          base0, base1;

  always #5 clk = ~clk;

  imem_loader dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_valid(byte_valid), .i_byte(byte_dat),
    .o_byte_ready(rdy0), .o_imem_we(we0), .o_imem_addr(addr0), .o_imem_wdata(wdata0),
    .o_core_rst_n(crn0), .o_busy(busy0), .o_done(done0), .o_err(err0)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_valid(byte_valid), .i_byte(byte_dat),
    .o_byte_ready(rdy1), .o_imem_we(we1), .o_imem_addr(addr1), .o_imem_wdata(wdata1),
    .o_core_rst_n(crn1), .o_busy(busy1), .o_done(done1), .o_err(err1)
  );

  // Log every write strobe seen mid-cycle
  always @(negedge clk) begin
    if (we0) begin wa0.push_back(addr0); wd0.push_back(wdata0); end
    if (we1) begin wa1.push_back(addr1); wd1.push_back(wdata1); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Send one byte after a random gap; returns 1 unit after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int cnt;
    idle($urandom_range(0, 2));
    byte_valid = 1'b1;
    byte_dat   = b;
    cnt = 0;
    while (!rdy0 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!rdy0) check("rdy_timeout", {31'b0, rdy0}, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_dat   = 8'hxx;
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_dat = 8'h00;
    idle(3);

    // Reset values
    check("rst_rdy",   {31'b0, rdy0},  32'd0);
    check("rst_we",    {31'b0, we0},   32'd0);
    check("rst_addr",  addr0,          32'd0);
    check("rst_wdata", wdata0,         32'd0);
    check("rst_crn",   {31'b0, crn0},  32'd0);
    check("rst_busy",  {31'b0, busy0}, 32'd0);
    check("rst_done",  {31'b0, done0}, 32'd0);
    check("rst_err",   {31'b0, err0},  32'd0);
    check("rst_addr1", addr1,          32'd0);
    rst = 1'b0;
    idle(2);

    // Good two-word image, random valid gaps
    pulse_start();
    check("start_busy", {31'b0, busy0}, 32'd1);
    check("start_rdy",  {31'b0, rdy0},  32'd1);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    send_stim();
    idle(2);
    check("good_nwr0",  wa0.size(), 32'd2);
    check("good_a0",    wa0[0], 32'h0000_0000);
    check("good_d0",    wd0[0], 32'h0000_0013);
    check("good_a1",    wa0[1], 32'h0000_0004);
    check("good_d1",    wd0[1], 32'h0000_006F);
    check("good_nwr1",  wa1.size(), 32'd2);
    check("base_a0",    wa1[0], 32'h0000_0100);
    check("base_d0",    wd1[0], 32'h0000_0013);
    check("base_a1",    wa1[1], 32'h0000_0104);
    check("base_d1",    wd1[1], 32'h0000_006F);
    check("good_done",  {31'b0, done0}, 32'd1);
    check("good_crn",   {31'b0, crn0},  32'd1);
    check("good_rdy",   {31'b0, rdy0},  32'd0);
    check("good_err",   {31'b0, err0},  32'd0);

    // Restart from RUN drops core reset immediately; empty image reloads to RUN
    pulse_start();
    check("rerun_crn",  {31'b0, crn0},  32'd0);
    check("rerun_busy", {31'b0, busy0}, 32'd1);
    base0 = wa0.size();
    stim = '{8'h00, 8'h00, 8'h00};
    send_stim();
    idle(2);
    check("empty_nwr",  wa0.size() - base0, 32'd0);
    check("empty_done", {31'b0, done0}, 32'd1);
    check("empty_crn",  {31'b0, crn0},  32'd1);

    // Bad checksum: both words written, then ERROR
    pulse_start();
    base0 = wa0.size();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D};
    send_stim();
    idle(2);
    check("bad_nwr",  wa0.size() - base0, 32'd2);
    check("bad_err",  {31'b0, err0},  32'd1);
    check("bad_crn",  {31'b0, crn0},  32'd0);
    check("bad_done", {31'b0, done0}, 32'd0);

    // Start pulse mid-load is ignored
    pulse_start();
    base0 = wa0.size();
    stim = '{8'h01, 8'h00};
    send_stim();
    pulse_start();
    check("ign_busy", {31'b0, busy0}, 32'd1);
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_stim();
    idle(2);
    check("ign_nwr",  wa0.size() - base0, 32'd1);
    check("ign_addr", wa0[base0], 32'h0000_0000);
    check("ign_data", wd0[base0], 32'hDDCC_BBAA);
    check("ign_done", {31'b0, done0}, 32'd1);

    // Length above MAX_WORDS (instance 1 only): ERROR right after LEN_HI
    pulse_start();
    stim = '{8'h05, 8'h00};
    send_stim();
    check("max_err1",  {31'b0, err1},  32'd1);
    check("max_rdy1",  {31'b0, rdy1},  32'd0);
    check("max_busy0", {31'b0, busy0}, 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);

    // Reset after the 5th payload byte abandons the image
    pulse_start();
    base0 = wa0.size();
    base1 = wa1.size();
    stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stim();
    #1;
    rst = 1'b1;
    #1;
    check("mid_rdy",   {31'b0, rdy0},  32'd0);
    check("mid_we",    {31'b0, we0},   32'd0);
    check("mid_addr",  addr1,          32'd0);
    check("mid_wdata", wdata0,         32'd0);
    check("mid_busy",  {31'b0, busy0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_dat   = 8'h66;
    idle(6);
    byte_valid = 1'b0;
    check("mid_nwr0", wa0.size() - base0, 32'd1);
    check("mid_nwr1", wa1.size() - base1, 32'd1);
    check("mid_w0",   wd0[base0], 32'h4433_2211);
    check("mid_a1",   wa1[base1], 32'h0000_0100);
    check("mid_crn",  {31'b0, crn0}, 32'd0);
    check("mid_idle", {31'b0, rdy0}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted image length in words.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 i_clk  in  1  single clock, all state on rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  single-cycle pulse that begins or restarts a load.
REQ-007 i_byte_valid  in  1  upstream byte stream valid.
REQ-008 i_byte  in  8  upstream byte.
REQ-009 o_byte_ready  out  1  loader accepts i_byte this cycle.
REQ-010 o_imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-011 o_imem_addr  out  32  word-aligned byte address.
REQ-012 o_imem_wdata  out  32  instruction word.
REQ-013 o_core_rst_n  out  1  active-low reset to the pipeline core (fetch/id/ex/mem/wb).
REQ-014 o_busy, o_done, o_err  out  1 each  loading / image running / load failed.

Function
REQ-015 A byte SHALL transfer only on a cycle with i_byte_valid && o_byte_ready; valid gaps SHALL be tolerated with no state change.
REQ-016 Stream format SHALL be: LEN_LO, LEN_HI (16-bit little-endian word count N), then 4*N payload bytes (little-endian words), then one checksum byte equal to the XOR of all payload bytes.
REQ-017 States SHALL be IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERROR.
REQ-018 IDLE/RUN/ERROR: i_start -> LEN0 next cycle; word index, byte index and checksum accumulator cleared.
REQ-019 LEN0: byte accepted -> LEN1; LEN1: byte accepted -> if N > MAX_WORDS then ERROR, else if N == 0 then CSUM, else DATA.
REQ-020 DATA: each accepted byte SHALL be XORed into the accumulator and shifted into the word at lane (byte index); the 4th byte completes a word.
REQ-021 On completing word k, o_imem_we SHALL be 1 in the following cycle only, with o_imem_addr = BASE_ADDR + 4*k (32-bit wrap) and o_imem_wdata = the assembled word.
REQ-022 After word N-1 completes, the state SHALL go to CSUM.
REQ-023 CSUM: accepted byte equal to accumulator -> RUN, otherwise -> ERROR.
REQ-024 o_byte_ready SHALL be 1 exactly in LEN0, LEN1, DATA, CSUM.
REQ-025 o_core_rst_n SHALL be 1 only in RUN; o_busy = 1 in LEN0..CSUM; o_done = 1 in RUN; o_err = 1 in ERROR. All are registered or state-decoded, glitch-free.
REQ-026 i_start during LEN0..CSUM SHALL be ignored.
REQ-027 i_start in RUN SHALL drop o_core_rst_n in the next cycle and reload.

Reset
REQ-028 On i_rst: state IDLE, o_byte_ready 0, o_imem_we 0, o_imem_addr 0, o_imem_wdata 0, o_core_rst_n 0, o_busy/o_done/o_err 0, counters and accumulator 0.
REQ-029 Reset asserted mid-load SHALL abandon the image with no further writes; core stays in reset until a new load succeeds.

Structure
REQ-030 Package imem_loader_pkg SHALL hold the state enum and the LEN/CSUM format constants.
REQ-031 A sub-module word_assembler (byte-lane shift, byte index, completion pulse) SHALL be used; the FSM, address counter and checksum stay in imem_loader.

Verification
REQ-032 Stream 02 00 13 00 00 00 6F 00 00 00 7C -> writes (0x0, 0x00000013), (0x4, 0x0000006F); RUN; o_core_rst_n=1, o_done=1.
REQ-033 Same stream with checksum byte 7D -> both writes occur, then ERROR, o_err=1, o_core_rst_n stays 0.
REQ-034 Stream 00 00 00 -> no o_imem_we, RUN.
REQ-035 MAX_WORDS=4, stream 05 00 -> ERROR the cycle after the second byte; o_byte_ready=0.
REQ-036 Random valid gaps with BASE_ADDR=0x100 -> identical writes at 0x100, 0x104; i_rst asserted after the 5th payload byte -> all outputs at reset values immediately; no further writes.
REQ-037 i_start pulse in RUN -> o_core_rst_n=0 next cycle, state LEN0, successful reload ends in RUN.
